// File: rtl/sel_rr_scheduler_pkg.sv
// Shared constants and state type for the round-robin selector scheduler.
package sel_pkg;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;
endpackage

// File: rtl/sel_rr_scheduler_if.sv
// Request/grant bundle between the requesting channels and the scheduler.
interface sel_rr_scheduler_if;
  import sel_pkg::*;

  logic              en;
  logic [NUM_CH-1:0] req;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] gnt;
  logic              valid;
  logic              switch;

  // Requester side: drives enable/requests, observes the grant.
  modport master (
    output en, req,
    input  sel, gnt, valid, switch
  );

  // Scheduler side.
  modport slave (
    input  en, req,
    output sel, gnt, valid, switch
  );
endinterface

// File: rtl/sel_rr_scheduler_rr_pick.sv
// Rotating priority encoder: first set request at or after start, wrapping 3->0.
module rr_pick
  import sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  start,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  // Scan offsets 0..3 from start; the lowest offset with a request wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = start + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sel_rr_scheduler.sv
// Round-robin scheduler producing the registered SEL/GNT for the 4-to-1 selector.
module sel_rr_scheduler
  import sel_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sel_rr_scheduler_if.slave   bus
);

  localparam int unsigned HCNT_W = $clog2(HOLD_MAX + 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_q, cur_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic              switch_q, switch_d;

  logic [SEL_W-1:0]  pick_start;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              release_c;

  // One encoder serves both states: in GRANT the search starts just past the
  // current channel, which equals the pointer value written on release.
  always_comb begin
    pick_start = (state_q == GRANT) ? cur_q + SEL_W'(1) : ptr_q;
  end

  rr_pick u_pick (
    .req   (bus.req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Grant ends on disable, on the holder dropping its request, or at the hold limit.
  always_comb begin
    release_c = !bus.en || !bus.req[cur_q] || (hcnt_q == HCNT_W'(HOLD_MAX));
  end

  // Next-state and next-output decision.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ptr_d    = ptr_q;
    hcnt_d   = hcnt_q;
    gnt_d    = gnt_q;
    valid_d  = valid_q;
    switch_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (bus.en && pick_found) begin
          state_d  = GRANT;
          cur_d    = pick_idx;
          hcnt_d   = HCNT_W'(1);
          gnt_d    = NUM_CH'(1) << pick_idx;
          valid_d  = 1'b1;
          switch_d = 1'b1;
        end
      end
      GRANT: begin
        if (!release_c) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end else begin
          ptr_d = cur_q + SEL_W'(1);
          if (bus.en && pick_found) begin
            cur_d    = pick_idx;
            hcnt_d   = HCNT_W'(1);
            gnt_d    = NUM_CH'(1) << pick_idx;
            valid_d  = 1'b1;
            switch_d = (pick_idx != cur_q);
          end else begin
            state_d = IDLE;
            hcnt_d  = '0;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      ptr_q    <= '0;
      hcnt_q   <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      ptr_q    <= ptr_d;
      hcnt_q   <= hcnt_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      switch_q <= switch_d;
    end
  end

  assign bus.sel    = cur_q;
  assign bus.gnt    = gnt_q;
  assign bus.valid  = valid_q;
  assign bus.switch = switch_q;

endmodule

// File: tb/tb_sel_rr_scheduler.sv
// Bench for sel_rr_scheduler: directed scenarios plus random traffic against a reference model.
module tb_sel_rr_scheduler;

  localparam int HOLD = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  sel_rr_scheduler_if bus ();

  sel_rr_scheduler #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  bit m_active;
  int m_cur;
  int m_ptr;
  int m_held;
  bit m_sw;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_cur = 0; m_ptr = 0; m_held = 0; m_sw = 0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] r);
    int c;
    m_sw = 0;
    if (!m_active) begin
      c = pick(r, m_ptr);
      if (e && c >= 0) begin
        m_active = 1; m_cur = c; m_held = 1; m_sw = 1;
      end
    end else if (e && r[m_cur] && m_held < HOLD) begin
      m_held++;
    end else begin
      m_ptr = (m_cur + 1) % 4;
      c = pick(r, m_ptr);
      if (e && c >= 0) begin
        m_sw = (c != m_cur); m_cur = c; m_held = 1;
      end else begin
        m_active = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] eg;
    eg = m_active ? (4'b0001 << m_cur) : 4'b0000;
    chk({tag, ".valid"},  8'(bus.valid),  8'(m_active));
    chk({tag, ".sel"},    8'(bus.sel),    8'(m_cur));
    chk({tag, ".gnt"},    8'(bus.gnt),    8'(eg));
    chk({tag, ".switch"}, 8'(bus.switch), 8'(m_sw));
  endtask

  // Apply inputs, take one rising edge, advance the model, compare 1 time unit later.
  task automatic cycle(input bit e, input logic [3:0] r, input string tag);
    bus.en  = e;
    bus.req = r;
    @(posedge clk);
    model_step(e, r);
    #1;
    chk_model(tag);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, ".rst_valid"},  8'(bus.valid),  8'h00);
    chk({tag, ".rst_gnt"},    8'(bus.gnt),    8'h00);
    chk({tag, ".rst_sel"},    8'(bus.sel),    8'h00);
    chk({tag, ".rst_switch"}, 8'(bus.switch), 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 4'b0000;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.valid", 8'(bus.valid), 8'h00);
    chk("reset.gnt",   8'(bus.gnt),   8'h00);
    chk("reset.sel",   8'(bus.sel),   8'h00);
    rst_n = 1'b1;

    // Single requester then drop.
    cycle(1, 4'b0001, "single");
    chk("single.gnt_exp", 8'(bus.gnt), 8'h01);
    chk("single.sw_exp",  8'(bus.switch), 8'h01);
    cycle(1, 4'b0000, "drop");
    chk("drop.valid_exp", 8'(bus.valid), 8'h00);
    chk("drop.sel_hold",  8'(bus.sel), 8'h00);

    // All requesting: 4 cycles per channel, rotation 0,1,2,3,0.
    async_reset("pre_rot");
    for (int n = 0; n < 20; n++) begin
      cycle(1, 4'b1111, "rot");
      chk("rot.sel_exp",   8'(bus.sel),    8'((n / 4) % 4));
      chk("rot.sw_exp",    8'(bus.switch), 8'(n % 4 == 0));
      chk("rot.valid_exp", 8'(bus.valid),  8'h01);
    end

    // Sole requester is re-granted at the hold limit without a gap.
    async_reset("pre_sole");
    for (int n = 0; n < 12; n++) begin
      cycle(1, 4'b0100, "sole");
      chk("sole.sel_exp", 8'(bus.sel),    8'h02);
      chk("sole.sw_exp",  8'(bus.switch), 8'(n == 0));
    end

    // Holder drops while another requests: hand-off on the same edge.
    async_reset("pre_handoff");
    cycle(1, 4'b0010, "ho_grant1");
    cycle(1, 4'b0011, "ho_hold");
    cycle(1, 4'b0011, "ho_hold");
    cycle(1, 4'b0001, "ho_switch");
    chk("ho.gnt_exp", 8'(bus.gnt), 8'h01);
    cycle(1, 4'b0000, "ho_idle");
    cycle(1, 4'b1101, "ho_ptr");
    chk("ho.ptr_sel", 8'(bus.sel), 8'h02);

    // Enable drop on channel 3, then pointer wraps to 0.
    async_reset("pre_en");
    cycle(1, 4'b1000, "en_grant3");
    cycle(1, 4'b1000, "en_hold");
    cycle(0, 4'b1000, "en_off");
    chk("en_off.gnt_exp", 8'(bus.gnt), 8'h00);
    cycle(1, 4'b1001, "en_back");
    chk("en_back.sel_exp", 8'(bus.sel), 8'h00);

    // Reset in the middle of a grant.
    cycle(1, 4'b1001, "mid_hold");
    async_reset("mid");
    cycle(1, 4'b0110, "post_rst");
    chk("post_rst.sel_exp", 8'(bus.sel), 8'h01);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit         e;
      logic [3:0] r;
      e = ($urandom_range(0, 9) != 0);
      r = 4'($urandom);
      cycle(e, r, "rand");
      if (n == 200) async_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sel_rr_scheduler.md
# sel_rr_scheduler

Round-robin scheduler that drives the 2-bit select of the team's 4-to-1 2-bit selector. Four channels raise requests; the block grants one at a time, holds each grant for a bounded number of cycles, and presents the winner as a registered SEL code plus a one-hot grant. It sits directly upstream of the selector: SEL here connects straight to the selector's SEL input, so the selector's OUT carries the granted channel's data.

## Interface
- HOLD_MAX, default 4: maximum consecutive cycles one channel keeps the grant while others wait; legal range 1..15.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  global enable; low forces release and blocks new grants.
- REQ  in  4  per-channel request; REQ[i] high means channel i wants the selector (0=A, 1=B, 2=C, 3=D).
- SEL  out  2  registered select code of the granted channel; feeds the selector's SEL.
- GNT  out  4  registered one-hot grant; all zero when idle.
- VALID  out  1  high while a grant is active; SEL is meaningful only when VALID=1.
- SWITCH  out  1  one-cycle pulse in the first cycle of a grant to a different channel than the previous grant, or the first grant after IDLE.

## Operation
- States: IDLE, GRANT. Internal: current channel CUR (2 bits), round-robin pointer PTR (2 bits), hold counter HCNT (width clog2(HOLD_MAX+1)).
- Pick rule (shared by both states): search REQ starting at index PTR, ascending, wrapping 3->0; first set bit wins.
- IDLE: if EN=1 and REQ!=0 -> GRANT with CUR=pick, HCNT=1, SWITCH=1. Otherwise stay; GNT=0, VALID=0, SEL holds last value.
- GRANT, release condition: EN=0, or REQ[CUR]=0, or HCNT==HOLD_MAX.
- GRANT, no release: stay; HCNT increments; outputs unchanged.
- GRANT, on release with EN=1: PTR<=CUR+1 (mod 4), pick against REQ using the new PTR (current channel last in order). If a channel is found: grant it on the same edge (no idle bubble), HCNT=1; SWITCH=1 only if the new channel differs from CUR. If none found: -> IDLE.
- Sole requester hitting HOLD_MAX is re-granted: CUR unchanged, HCNT=1, SWITCH=0, VALID stays 1.
- EN=0 in GRANT: -> IDLE next edge; PTR<=CUR+1.
- SEL and GNT always agree: GNT = 1<<SEL whenever VALID=1.

## Timing
- Latency: REQ/EN sampled at edge k; GNT/SEL/VALID/SWITCH reflect the decision after edge k. All outputs registered, no combinational REQ->output paths.
- Grant duration: at most HOLD_MAX cycles of VALID for a channel while any other channel is requesting.
- Reset (RST_N low, any time, asynchronous): state=IDLE, SEL=00, GNT=0000, VALID=0, SWITCH=0, PTR=0, HCNT=0. First grant after release of reset favours channel 0.
- REQ[CUR] dropping and another REQ rising on the same edge: treated as release plus pick; the new requester is granted on that edge.
- REQ changes on non-granted channels during a grant have no effect until the next release.

## Structure
- Package sel_pkg: channel count constant (4), SEL width constant (2), state enum {IDLE, GRANT}.
- Sub-module rr_pick: combinational rotating priority encoder (inputs REQ[3:0], start PTR[1:0]; outputs FOUND, IDX[1:0]). Instantiated once in the top.
- The top holds the FSM, HCNT, PTR and output registers only.

## Test plan
- Reset then REQ=0001, EN=1 -> one edge later VALID=1, SEL=00, GNT=0001, SWITCH=1; drop REQ -> next edge VALID=0, GNT=0000, SEL stays 00.
- HOLD_MAX=4, REQ=1111 held -> grants rotate 0,1,2,3,0 with exactly 4 VALID cycles each, SWITCH pulsing at each change, no VALID gaps.
- HOLD_MAX=4, REQ=0100 held for 12 cycles -> SEL=10 continuously, VALID never drops, SWITCH only on the first cycle.
- Grant on channel 1, REQ=0011 then REQ[1] drops after 2 cycles -> next edge SEL=00, GNT=0001; PTR now 2, so a later REQ=1101 after release grants channel 2.
- EN deasserted mid-grant on channel 3 -> next edge VALID=0, GNT=0000; EN back with REQ=1001 -> channel 0 granted (PTR wrapped to 0).
- RST_N pulsed low mid-grant, asynchronously between edges -> outputs zero immediately, SEL=00; after release REQ=0110 grants channel 1.
